// File: rtl/packet_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : packet_source_arbiter
// Description : Round-robin arbiter that hands one of NUM_SRC packet
//               sources to a single consumer. A packet is owned from
//               selection until the source drops its trigger. If the
//               consumer stalls for TIMEOUT cycles, the rest of the packet
//               is popped from the source FIFO and discarded.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               src_trig_i       - per-source packet-queued flags
//               src_len_i        - per-source byte lengths, 16 bits each
//               src_data_i       - per-source FIFO head words, 32 bits each
//               src_rden_o       - one-hot FIFO pop strobe to the sources
//               out_trig_o       - packet presented to the consumer
//               out_len_o        - byte length of the presented packet
//               out_data_o       - current word of the granted source
//               out_rden_i       - consumer pop strobe
//               grant_o          - one-hot owner, zero when idle
//               pkt_cnt_o        - completed packets, wrapping
//               abort_cnt_o      - timed-out packets, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module packet_source_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_trig_i,
  input  logic [NUM_SRC*16-1:0]  src_len_i,
  input  logic [NUM_SRC*32-1:0]  src_data_i,
  output logic [NUM_SRC-1:0]     src_rden_o,
  output logic                   out_trig_o,
  output logic [15:0]            out_len_o,
  output logic [31:0]            out_data_o,
  input  logic                   out_rden_i,
  output logic [NUM_SRC-1:0]     grant_o,
  output logic [31:0]            pkt_cnt_o,
  output logic [15:0]            abort_cnt_o
);

  localparam int         c_IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [15:0] c_STALL_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_LATCH   = 3'd1;
  localparam logic [2:0] c_XFER    = 3'd2;
  localparam logic [2:0] c_DRAIN   = 3'd3;
  localparam logic [2:0] c_RELEASE = 3'd4;

  logic [2:0]      state_q,      state_d;
  logic [c_IW-1:0] last_grant_q, last_grant_d;
  logic [c_IW-1:0] sel_q,        sel_d;
  logic [15:0]     len_q,        len_d;
  logic [15:0]     words_q,      words_d;
  logic [15:0]     rd_cnt_q,     rd_cnt_d;
  logic [15:0]     stall_cnt_q,  stall_cnt_d;
  logic [31:0]     pkt_cnt_q,    pkt_cnt_d;
  logic [15:0]     abort_cnt_q,  abort_cnt_d;

  logic [c_IW-1:0] w_rr_hi_sel;
  logic            w_rr_hi_found;
  logic [c_IW-1:0] w_rr_lo_sel;
  logic [c_IW-1:0] w_rr_sel;
  logic [15:0]     w_sel_len;
  logic [31:0]     w_sel_data;
  logic [16:0]     w_sel_words;
  logic            w_last_word;

  // Round-robin pick. Scanning downwards leaves the lowest requester in each
  // class: the lowest one above last_grant wins, otherwise the search wraps
  // to the lowest requester overall.
  always_comb begin
    w_rr_hi_sel   = '0;
    w_rr_hi_found = 1'b0;
    w_rr_lo_sel   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_trig_i[i]) begin
        if (c_IW'(i) > last_grant_q) begin
          w_rr_hi_sel   = c_IW'(i);
          w_rr_hi_found = 1'b1;
        end
        w_rr_lo_sel = c_IW'(i);
      end
    end
    w_rr_sel = w_rr_hi_found ? w_rr_hi_sel : w_rr_lo_sel;
  end

  // Fields of the selected source.
  always_comb begin
    w_sel_len  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_q == c_IW'(i)) begin
        w_sel_len  = src_len_i[i*16 +: 16];
        w_sel_data = src_data_i[i*32 +: 32];
      end
    end
  end

  // Widened to 17 bits so lengths near 16'hFFFF do not wrap when rounding up.
  assign w_sel_words = ({1'b0, w_sel_len} + 17'd3) >> 2;
  assign w_last_word = (rd_cnt_q == (words_q - 16'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_IDLE;
      last_grant_q <= c_IW'(NUM_SRC - 1);
      sel_q        <= '0;
      len_q        <= '0;
      words_q      <= '0;
      rd_cnt_q     <= '0;
      stall_cnt_q  <= '0;
      pkt_cnt_q    <= '0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      words_q      <= words_d;
      rd_cnt_q     <= rd_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    len_d        = len_q;
    words_d      = words_q;
    rd_cnt_d     = rd_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    case (state_q)
      c_IDLE: begin
        if (|src_trig_i) begin
          sel_d   = w_rr_sel;
          state_d = c_LATCH;
        end
      end
      c_LATCH: begin
        len_d       = w_sel_len;
        words_d     = w_sel_words[15:0];
        rd_cnt_d    = '0;
        stall_cnt_d = '0;
        state_d     = (w_sel_words == 17'd0) ? c_RELEASE : c_XFER;
      end
      c_XFER: begin
        // A pop in the timeout cycle takes priority over the abort.
        if (out_rden_i) begin
          rd_cnt_d    = rd_cnt_q + 16'd1;
          stall_cnt_d = '0;
          if (w_last_word) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            state_d   = c_RELEASE;
          end
        end else begin
          stall_cnt_d = stall_cnt_q + 16'd1;
          // This stall cycle brings the count to TIMEOUT.
          if (stall_cnt_q == c_STALL_LAST) begin
            if (abort_cnt_q != 16'hFFFF) begin
              abort_cnt_d = abort_cnt_q + 16'd1;
            end
            state_d = c_DRAIN;
          end
        end
      end
      c_DRAIN: begin
        rd_cnt_d = rd_cnt_q + 16'd1;
        if (w_last_word) begin
          state_d = c_RELEASE;
        end
      end
      c_RELEASE: begin
        if (!src_trig_i[sel_q]) begin
          last_grant_d = sel_q;
          state_d      = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Outputs. Forced low while rst is high so nothing leaks during reset.
  always_comb begin
    src_rden_o  = '0;
    out_trig_o  = 1'b0;
    out_len_o   = '0;
    out_data_o  = '0;
    grant_o     = '0;
    pkt_cnt_o   = '0;
    abort_cnt_o = '0;
    if (!rst) begin
      pkt_cnt_o   = pkt_cnt_q;
      abort_cnt_o = abort_cnt_q;
      if (state_q != c_IDLE) begin
        grant_o[sel_q] = 1'b1;
      end
      if (state_q == c_XFER) begin
        out_trig_o        = 1'b1;
        out_len_o         = len_q;
        out_data_o        = w_sel_data;
        src_rden_o[sel_q] = out_rden_i;
      end
      if (state_q == c_DRAIN) begin
        src_rden_o[sel_q] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/packet_source_arbiter.md
PACKET_SOURCE_ARBITER -- requirements
Module: packet_source_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4: number of packet sources, legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: consumer-stall cycles before a packet is aborted, legal range 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port src_trig, input, NUM_SRC bits: bit i high means source i has a packet queued.
REQ-006 The block SHALL have port src_len, input, NUM_SRC*16 bits: source i byte length in bits [16i+15:16i].
REQ-007 The block SHALL have port src_data, input, NUM_SRC*32 bits: source i FIFO head word in bits [32i+31:32i].
REQ-008 The block SHALL have port src_rden, output, NUM_SRC bits: one-hot FIFO pop strobe to source i.
REQ-009 The block SHALL have port out_trig, output, 1 bit: a packet is presented to the consumer.
REQ-010 The block SHALL have port out_len, output, 16 bits: byte length of the presented packet.
REQ-011 The block SHALL have port out_data, output, 32 bits: current word of the granted source.
REQ-012 The block SHALL have port out_rden, input, 1 bit: consumer pop strobe.
REQ-013 The block SHALL have port grant, output, NUM_SRC bits: one-hot index of the owning source, zero when idle.
REQ-014 The block SHALL have port pkt_cnt, output, 32 bits: completed packets, wrapping at 2^32.
REQ-015 The block SHALL have port abort_cnt, output, 16 bits: timed-out packets, saturating at 16'hFFFF.

Function
REQ-016 The FSM SHALL have states IDLE, LATCH, XFER, DRAIN and RELEASE, all registered.
REQ-017 In IDLE, when any src_trig bit is high, the block SHALL select a source round-robin, searching from last_grant+1 modulo NUM_SRC, and go to LATCH.
REQ-018 In LATCH, the block SHALL register sel, len_q = src_len[sel] and words_q = (17-bit len_q + 3) >> 2; go to RELEASE if words_q==0, else to XFER.
REQ-019 grant SHALL be one-hot of sel in LATCH, XFER, DRAIN and RELEASE, and 0 in IDLE.
REQ-020 In XFER, the outputs SHALL be combinational: out_trig=1, out_len=len_q, out_data=src_data[sel], src_rden[sel]=out_rden, and all other src_rden bits 0.
REQ-021 Outside XFER, out_trig, out_len and out_data SHALL be 0, and out_rden SHALL be ignored.
REQ-022 rd_cnt SHALL increment on each out_rden in XFER; when out_rden is high and rd_cnt==words_q-1, the block SHALL increment pkt_cnt and go to RELEASE.
REQ-023 stall_cnt SHALL clear on LATCH and on every out_rden, and increment on each XFER cycle without out_rden.
REQ-024 When stall_cnt reaches TIMEOUT, the block SHALL go to DRAIN, and abort_cnt SHALL increment with saturation.
REQ-025 When out_rden and the timeout fall in the same cycle, out_rden SHALL win: the word is counted and stall_cnt clears.
REQ-026 In DRAIN, src_rden[sel] SHALL be 1 every cycle; rd_cnt SHALL continue counting and the FSM SHALL go to RELEASE after the cycle with rd_cnt==words_q-1.
REQ-027 A drained packet SHALL NOT increment pkt_cnt.
REQ-028 In RELEASE, the block SHALL wait until src_trig[sel]==0, then set last_grant=sel and go to IDLE; this guarantees at least one idle cycle between packets.
REQ-029 The block SHALL ignore src_trig changes of non-granted sources during a packet, and SHALL never pre-empt a packet.
REQ-030 Selection latency SHALL be exactly 2 cycles (trig seen in IDLE -> XFER).

Reset
REQ-031 When rst is high at a clock edge, the block SHALL set state=IDLE, last_grant=NUM_SRC-1, sel=0, len_q=0, words_q=0, rd_cnt=0, stall_cnt=0, pkt_cnt=0 and abort_cnt=0.
REQ-032 During and after reset, all outputs SHALL be 0 (out_trig, out_len, out_data, src_rden, grant, pkt_cnt, abort_cnt).
REQ-033 A reset asserted mid-packet SHALL abandon the packet at once without draining; the first grant after reset SHALL go to source 0 if it requests.

Verification
REQ-034 Scenario single source: source 1, len=8, consumer pops 2 words back to back -> grant=4'b0010 for the packet, out_data matches the FIFO words, pkt_cnt=1, and src_trig[1] dropping returns the FSM to IDLE.
REQ-035 Scenario round-robin: all four src_trig held high, len=4, consumer always ready -> grant order 0,1,2,3,0, with each source re-granted only after its trig drops.
REQ-036 Scenario odd length: len=5 -> exactly 2 src_rden pulses; len=0 -> no pulses and pkt_cnt unchanged.
REQ-037 Scenario timeout: TIMEOUT=16, len=16, consumer pops 1 word then stalls -> DRAIN begins 16 cycles after the last pop, issues 3 src_rden pulses, abort_cnt=1, pkt_cnt=0.
REQ-038 Scenario mid-packet reset: assert rst during XFER -> the next cycle shows all outputs 0 and the FSM in IDLE, and the next grant goes to the lowest requesting source.
